// File: rtl/tdc_div_pkg.sv
// Shared types and constants for the divider request scheduler.
package tdc_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Bit positions inside out_err
  localparam int unsigned ERR_DIVZ = 0;
  localparam int unsigned ERR_TMO  = 1;

  // Divider start-to-done latency in cycles
  localparam int unsigned DIV_LATENCY = 36;

  // Quotient reported for divide-by-zero and timeout
  localparam logic [15:0] DIVZ_Q = 16'hFFFF;

endpackage

// File: rtl/tdc_div_fifo.sv
// Synchronous request FIFO; head is read from the registered storage at rd_ptr.
module tdc_div_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_div_sched.sv
// Schedules queued num/den/tag requests onto the shared serial divider,
// guarding against divide-by-zero and a missing done pulse.
module tdc_div_sched
  import tdc_div_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned TIMEOUT    = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_num,
  input  logic [15:0]      in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_en,
  output logic [15:0]      div_a,
  output logic [15:0]      div_b,
  input  logic [15:0]      div_q,
  input  logic [15:0]      div_r,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_q,
  output logic [15:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_err,
  output logic             busy
);

  localparam int unsigned DW = 32 + TAG_W;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push_c;
  logic             pop_c;
  logic             ld_divz_c;
  logic             ld_done_c;
  logic             ld_tmo_c;
  logic [TW-1:0]    tmo_cnt;
  logic [TAG_W-1:0] tag_q;
  logic [15:0]      hd_num;
  logic [15:0]      hd_den;
  logic [TAG_W-1:0] hd_tag;

  assign hd_num   = fifo_head[DW-1 -: 16];
  assign hd_den   = fifo_head[DW-17 -: 16];
  assign hd_tag   = fifo_head[TAG_W-1:0];
  assign in_ready = !fifo_full;
  assign push_c   = in_valid && in_ready;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

  tdc_div_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   ({in_num, in_den, in_tag}),
    .pop   (pop_c),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and load strobes
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    ld_divz_c = 1'b0;
    ld_done_c = 1'b0;
    ld_tmo_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          if (hd_den == '0) begin
            ld_divz_c = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          ld_done_c = 1'b1;
          state_d   = HOLD;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          ld_tmo_c = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider operands, timeout counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_en    <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      tag_q     <= '0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_tag   <= '0;
      out_err   <= '0;
    end else begin
      div_en    <= (state_d == ISSUE);
      out_valid <= (state_d == HOLD);

      if (pop_c) begin
        div_a <= hd_num;
        div_b <= hd_den;
        tag_q <= hd_tag;
      end

      if (state_q == ISSUE)     tmo_cnt <= '0;
      else if (state_q == WAIT) tmo_cnt <= tmo_cnt + TW'(1);

      if (ld_divz_c) begin
        out_q             <= DIVZ_Q;
        out_r             <= hd_num;
        out_tag           <= hd_tag;
        out_err           <= '0;
        out_err[ERR_DIVZ] <= 1'b1;
      end else if (ld_done_c) begin
        out_q   <= div_q;
        out_r   <= div_r;
        out_tag <= tag_q;
        out_err <= '0;
      end else if (ld_tmo_c) begin
        out_q            <= DIVZ_Q;
        out_r            <= '0;
        out_tag          <= tag_q;
        out_err          <= '0;
        out_err[ERR_TMO] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdc_div_sched.sv
// Directed testbench for the divider request scheduler with a 36-cycle divider model.
module tb_tdc_div_sched;
  import tdc_div_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TAG_W      = 8;
  localparam int unsigned TIMEOUT    = 48;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_num = '0;
  logic [15:0]      in_den = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_en;
  logic [15:0]      div_a;
  logic [15:0]      div_b;
  logic [15:0]      div_q;
  logic [15:0]      div_r;
  logic             div_done;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_q;
  logic [15:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic        suppress = 1'b0;
  logic        stray    = 1'b0;
  logic        model_done;
  logic [15:0] model_q;
  logic [15:0] model_r;
  logic        pend;
  int unsigned dcnt;
  logic [15:0] la;
  logic [15:0] lb;

  assign div_done = model_done | stray;
  assign div_q    = model_q;
  assign div_r    = model_r;

  tdc_div_sched #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .in_tag    (in_tag),
    .div_en    (div_en),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_done  (div_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Serial divider model: div_en in cycle N gives a one-cycle done in cycle N+36
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= 1'b0;
      dcnt       <= 0;
      model_done <= 1'b0;
      model_q    <= '0;
      model_r    <= '0;
      la         <= '0;
      lb         <= '0;
    end else begin
      model_done <= 1'b0;
      if (div_en && !suppress) begin
        pend <= 1'b1;
        dcnt <= DIV_LATENCY - 1;
        la   <= div_a;
        lb   <= div_b;
      end else if (pend) begin
        if (dcnt == 1) begin
          pend       <= 1'b0;
          model_done <= 1'b1;
          model_q    <= (lb == 0) ? 16'hFFFF : la / lb;
          model_r    <= (lb == 0) ? 16'h0000 : la % lb;
        end
        dcnt <= dcnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, div_en, out_valid, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got ready/en/valid/busy=%b want 1000", {in_ready, div_en, out_valid, busy});
    end
    checks++;
    if ({div_a, div_b, out_q, out_r, out_tag, out_err} !== '0) begin
      failures++;
      $display("FAIL reset_data got a=%h b=%h q=%h r=%h tag=%h err=%b want all zero",
               div_a, div_b, out_q, out_r, out_tag, out_err);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int  cyc    = 0;
    int  en_cnt = 0;
    int  en_cyc = 0;
    bit  got    = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_num = 16'd1000; in_den = 16'd7; in_tag = 8'h11;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_in_ready got %b want 1", in_ready);
    end
    for (int i = 1; i <= 100 && !got; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      if (div_en === 1'b1) begin en_cnt++; en_cyc = i; end
      if (out_valid === 1'b1) begin got = 1; cyc = i; end
    end
    checks++;
    if (cyc != 39) begin
      failures++;
      $display("FAIL basic_latency got cycle %0d want 39", cyc);
    end
    checks++;
    if (en_cnt != 1 || en_cyc != 2) begin
      failures++;
      $display("FAIL basic_div_en got %0d pulses last at cycle %0d want 1 pulse at cycle 2", en_cnt, en_cyc);
    end
    checks++;
    if ({out_q, out_r, out_err, out_tag} !== {16'd142, 16'd6, 2'b00, 8'h11}) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d err=%b tag=%h want q=142 r=6 err=00 tag=11",
               out_q, out_r, out_err, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_q !== 16'd142 || div_a !== 16'd1000 || div_b !== 16'd7) begin
      failures++;
      $display("FAIL basic_hold got valid=%b q=%0d a=%0d b=%0d want 1 142 1000 7",
               out_valid, out_q, div_a, div_b);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_release got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_divz();
    int cyc    = 0;
    int en_cnt = 0;
    bit got    = 0;
    in_valid = 1'b1; in_num = 16'h1234; in_den = 16'h0000; in_tag = 8'h5A;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      if (div_en === 1'b1) en_cnt++;
      if (out_valid === 1'b1) begin got = 1; cyc = i; end
    end
    checks++;
    if (cyc != 2 || en_cnt != 0) begin
      failures++;
      $display("FAIL divz_timing got valid cycle %0d div_en pulses %0d want 2 and 0", cyc, en_cnt);
    end
    checks++;
    if ({out_q, out_r, out_err, out_tag} !== {16'hFFFF, 16'h1234, 2'b01, 8'h5A}) begin
      failures++;
      $display("FAIL divz_result got q=%h r=%h err=%b tag=%h want ffff 1234 01 5a",
               out_q, out_r, out_err, out_tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0]      nums [6] = '{16'd50000, 16'd100, 16'hFFFF, 16'd5, 16'd0, 16'd77};
    logic [15:0]      dens [6] = '{16'd3, 16'd10, 16'd1, 16'd9, 16'd3, 16'd0};
    logic [15:0]      eq   [6] = '{16'd16666, 16'd10, 16'hFFFF, 16'd0, 16'd0, 16'hFFFF};
    logic [15:0]      er   [6] = '{16'd2, 16'd0, 16'd0, 16'd5, 16'd0, 16'd77};
    logic [1:0]       ee   [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [TAG_W-1:0] et   [6] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    bit got = 0;
    int idx = 0;
    bit acc;
    out_ready = 1'b0;
    in_valid = 1'b1; in_num = nums[0]; in_den = dens[0]; in_tag = et[0];
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (out_valid === 1'b1) got = 1;
      else tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL b2b_first_hold got no out_valid within 60 cycles want valid");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_num = nums[i+1]; in_den = dens[i+1]; in_tag = et[i+1];
      checks++;
      if (in_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL b2b_in_ready push %0d got %b want %b", i, in_ready, (i < 4) ? 1'b1 : 1'b0);
      end
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 400 && idx < 6; c++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if ({out_q, out_r, out_err, out_tag} !== {eq[idx], er[idx], ee[idx], et[idx]}) begin
          failures++;
          $display("FAIL b2b_result %0d got q=%h r=%h err=%b tag=%h want q=%h r=%h err=%b tag=%h",
                   idx, out_q, out_r, out_err, out_tag, eq[idx], er[idx], ee[idx], et[idx]);
        end
        idx++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (idx != 6 || in_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got %0d results pending=%b busy=%b want 6 0 0", idx, in_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    bit got = 0;
    int bad = 0;
    suppress = 1'b1;
    in_valid = 1'b1; in_num = 16'h0100; in_den = 16'h0010; in_tag = 8'h33;
    for (int i = 1; i <= 120 && !got; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin got = 1; cyc = i; end
    end
    checks++;
    if (cyc != 2 + TIMEOUT + 1) begin
      failures++;
      $display("FAIL tmo_latency got cycle %0d want %0d", cyc, 2 + TIMEOUT + 1);
    end
    checks++;
    if ({out_q, out_r, out_err, out_tag} !== {16'hFFFF, 16'h0000, 2'b10, 8'h33}) begin
      failures++;
      $display("FAIL tmo_result got q=%h r=%h err=%b tag=%h want ffff 0000 10 33",
               out_q, out_r, out_err, out_tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    suppress = 1'b0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tmo_stray_done got %0d cycles with valid/busy want 0", bad);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_num = 16'd300; in_den = 16'd4; in_tag = 8'h40;
    tick();
    in_num = 16'd8; in_den = 16'd2; in_tag = 8'h41;
    tick();
    in_num = 16'd9; in_den = 16'd3; in_tag = 8'h42;
    tick();
    in_valid = 1'b0;
    for (int i = 3; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b1 || div_a !== 16'd300 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got busy=%b a=%0d valid=%b ready=%b want 1 300 0 1",
               busy, div_a, out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, div_en, out_valid, busy} !== 4'b1000 ||
        {div_a, div_b, out_q, out_r, out_tag, out_err} !== '0) begin
      failures++;
      $display("FAIL rst_async got ready/en/valid/busy=%b a=%h b=%h q=%h r=%h tag=%h err=%b want 1000 and zeros",
               {in_ready, div_en, out_valid, busy}, div_a, div_b, out_q, out_r, out_tag, out_err);
    end
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0 || div_en !== 1'b0) bad++;
    end
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_after got %0d cycles with valid/busy/div_en want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divz();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_div_sched.md
# tdc_div_sched

Request scheduler that sits directly upstream of the shared 16-bit serial divider in the AS6500 TDC control path. Buffers numerator/denominator/tag requests in a small FIFO and issues them one at a time to the divider. Returns quotient/remainder with the originating tag over a valid/ready port. Guards the divider against divide-by-zero and a missing `done`.

## Interface
- `FIFO_DEPTH`, 4: request entries buffered; power of two, ≥2.
- `TAG_W`, 8: width of the opaque request tag.
- `TIMEOUT`, 48: cycles in WAIT without `div_done` before abort; must exceed 36.

Ports (one clock; reset asynchronous, active-low):
- `clk` in 1: system clock.
- `rst` in 1: async active-low reset; the same net drives the divider's `rst`.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_num` in 16: dividend.
- `in_den` in 16: divisor.
- `in_tag` in TAG_W: tag returned with the result.
- `div_en` out 1: one-cycle start pulse to the divider.
- `div_a` out 16: dividend to the divider; stable from ISSUE until WAIT exits.
- `div_b` out 16: divisor to the divider; same stability rule as `div_a`.
- `div_q` in 16: divider quotient.
- `div_r` in 16: divider remainder.
- `div_done` in 1: divider single-cycle completion pulse.
- `out_valid` out 1: result present.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_q` out 16: quotient.
- `out_r` out 16: remainder.
- `out_tag` out TAG_W: tag of the request.
- `out_err` out 2: bit0 = divide-by-zero, bit1 = timeout.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.

## Operation
- Reset values: `in_ready`=1, `div_en`=0, `div_a`=`div_b`=0, `out_valid`=0, `out_q`=`out_r`=0, `out_tag`=0, `out_err`=0, `busy`=0. FIFO is emptied, the timeout counter is cleared, and the FSM returns to IDLE.
- FIFO:
  - `in_ready` = count < FIFO_DEPTH.
  - There is no bypass: a request always takes one cycle in the FIFO.
  - A simultaneous push and pop leaves the count unchanged.
  - When the FIFO is full, `in_ready` is 0 even if a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head and latch num/den/tag.
    - den≠0 → ISSUE.
    - den=0 → load `out_q`=16'hFFFF, `out_r`=num, `out_err`=2'b01 → HOLD. The divider is not started.
  - ISSUE: `div_en`=1 for exactly this cycle; `div_a`/`div_b` hold the latched values; clear the timeout counter → WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On `div_done`: capture `div_q`/`div_r`, set `out_err`=0 → HOLD.
    - Else, when the counter reaches TIMEOUT−1: `out_q`=16'hFFFF, `out_r`=0, `out_err`=2'b10 → HOLD.
  - HOLD: `out_valid`=1; outputs stay stable until `out_ready`. On the handshake, `out_valid` drops next cycle → IDLE.
- Pulses of `div_done` outside WAIT (for example a late pulse after a timeout) are ignored. They never produce an output.
- Results are returned in request order; one division is outstanding at a time.
- `div_a`/`div_b` keep their last value outside ISSUE/WAIT; they are don't-care to the divider.

## Timing
- Divider contract: `div_done` rises 36 cycles after the `div_en` cycle (`div_en` in cycle N → `div_done` in cycle N+36), and stays high for 1 cycle.
- Latency from accept (cycle 0, FIFO empty, FSM idle):
  - cycle 1: IDLE pop;
  - cycle 2: ISSUE;
  - cycle 38: `div_done`;
  - cycle 39: `out_valid` high.
- Divide-by-zero: accept in cycle 0 → `out_valid` in cycle 2.
- Timeout: `out_valid` appears TIMEOUT+1 cycles after ISSUE.
- Throughput with `out_ready` tied high: one result per 39 cycles (IDLE + ISSUE + 36 wait cycles + HOLD).
- Reset asserted mid-operation clears everything immediately, in the divider as well. There is no orphan `done`, and no result is emitted for in-flight or queued requests.

## Structure
- Package `tdc_div_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT/HOLD);
  - `ERR_DIVZ`=0, `ERR_TMO`=1 bit indices;
  - `DIV_LATENCY`=36;
  - `DIVZ_Q`=16'hFFFF.
- Sub-module `tdc_div_fifo`: synchronous FIFO, width 32+TAG_W, depth FIFO_DEPTH. It has push/pop/full/empty/count, async active-low reset, and registered head output.
- Top: the FSM, the timeout counter, and the output registers.

## Test plan
- Basic: num=1000, den=7, tag=0x11 → `out_q`=142, `out_r`=6, `out_err`=0, `out_valid` 39 cycles after accept; `div_en` high exactly 1 cycle.
- Divide-by-zero: num=0x1234, den=0 → `out_q`=0xFFFF, `out_r`=0x1234, `out_err`=01, `out_valid` at cycle 2; `div_en` never asserts.
- Backpressure and ordering: push 5 back-to-back requests with `out_ready`=0 → `in_ready` drops after the 4th push (depth 4). Releasing `out_ready` then yields all results in order with correct tags.
- Timeout: divider model suppresses `div_done` → `out_err`=10, `out_q`=0xFFFF, `out_r`=0 after TIMEOUT+1 cycles. A later stray `div_done` produces no output.
- Reset mid-WAIT: assert `rst` 10 cycles after ISSUE with 2 requests queued → all outputs return to reset values asynchronously. After release, there is no `out_valid` and `busy`=0.
- Edge operands: 0xFFFF/1 → q=0xFFFF, r=0; 5/9 → q=0, r=5; 0/3 → q=0, r=0.
